// File: rtl/spi3w_pkg.sv
// Shared constants for the three-wire SPI datapath, control FSM and testbench.
// Frame is R/W bit + address followed by data, shifted MSB-first.
package spi3w_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;
  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int RW_BIT  = FRAME_W - 1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [CNT_W-1:0] ADDR_CNT = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

  function automatic logic is_data_phase(input logic [CNT_W-1:0] cnt);
    return cnt >= ADDR_CNT;
  endfunction

endpackage

// File: rtl/spi3w_bitcounter.sv
// Bit index counter for the SPI frame: synchronous clear beats enable, wraps naturally.
module spi3w_bitcounter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + W'(1);
  end

endmodule

// File: rtl/spi_three_wire_datapath.sv
// Three-wire SPI datapath: frame shift register, line turnaround for read data
// phase, serial read capture and parallel byte output with a one-cycle valid.
module spi_three_wire_datapath
  import spi3w_pkg::*;
(
  input  logic               CLK,
  input  logic               reset,
  input  logic [FRAME_W-1:0] DIN,
  input  logic               LDEN,
  input  logic               SHEN,
  input  logic               bitcountEN,
  input  logic               rstbitcount,
  input  logic               SCEN,
  input  logic               SDI,
  output logic [CNT_W-1:0]   bitcount,
  output logic               SDO,
  output logic               SDOEN,
  output logic [DATA_W-1:0]  DOUT,
  output logic               DVALID
);

  logic [FRAME_W-1:0] sreg;
  logic               rw_q;
  // Only the low DATA_W-1 read bits are kept; the last bit comes straight from SDI.
  logic [DATA_W-2:0]  rsh;
  logic               data_phase;
  logic               capture;
  logic               last_bit;

  spi3w_bitcounter #(.W(CNT_W)) u_bitcounter (
    .clk   (CLK),
    .rst_n (reset),
    .clr   (rstbitcount),
    .en    (bitcountEN),
    .count (bitcount)
  );

  assign data_phase = is_data_phase(bitcount);
  assign capture    = SHEN & ~LDEN & (rw_q == RW_READ) & data_phase;
  assign last_bit   = (bitcount == LAST_CNT);
  assign SDO        = sreg[FRAME_W-1];
  assign SDOEN      = SCEN & ~((rw_q == RW_READ) & data_phase);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
      rw_q <= RW_WRITE;
    end else if (LDEN) begin
      sreg <= DIN;
      rw_q <= DIN[RW_BIT];
    end else if (SHEN) begin
      sreg <= {sreg[FRAME_W-2:0], 1'b0};
    end
  end

  // A fresh load discards any partial read left behind by an aborted frame.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      rsh <= '0;
    else if (LDEN)
      rsh <= '0;
    else if (capture)
      rsh <= {rsh[DATA_W-3:0], SDI};
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      DOUT   <= '0;
      DVALID <= 1'b0;
    end else begin
      DVALID <= capture & last_bit;
      if (capture && last_bit)
        DOUT <= {rsh, SDI};
    end
  end

endmodule

// File: tb/tb_spi_three_wire_datapath.sv
// Directed self-checking bench: table of full frames plus hand-written corner sequences.
module tb_spi_three_wire_datapath;
  import spi3w_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic [FRAME_W-1:0] din;
  logic               lden, shen, bitcountEn, rstBitcount, scen, sdi;
  logic [CNT_W-1:0]   bitcount;
  logic               sdo, sdoen, dvalid;
  logic [DATA_W-1:0]  dout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string             name;
    logic [15:0]       din;
    logic [7:0]        sdiByte;
    logic [7:0]        expDout;
    logic              expDvalid;
  } vec_t;

  vec_t vecs[3];

  always #5 clk = ~clk;

  spi_three_wire_datapath dut (
    .CLK         (clk),
    .reset       (reset),
    .DIN         (din),
    .LDEN        (lden),
    .SHEN        (shen),
    .bitcountEN  (bitcountEn),
    .rstbitcount (rstBitcount),
    .SCEN        (scen),
    .SDI         (sdi),
    .bitcount    (bitcount),
    .SDO         (sdo),
    .SDOEN       (sdoen),
    .DOUT        (dout),
    .DVALID      (dvalid)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic l, input logic s, input logic en, input logic clr,
                               input logic sc, input logic d);
    lden = l; shen = s; bitcountEn = en; rstBitcount = clr; scen = sc; sdi = d;
  endtask

  task automatic loadFrame(input logic [15:0] value);
    din = value;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic runFrame(input vec_t v);
    int  pulses;
    logic isRead;
    isRead = v.din[15];
    pulses = 0;
    loadFrame(v.din);
    for (int i = 0; i < 16; i++) begin
      checkOutput({v.name, " bitcount"}, 16'(bitcount), 16'(i));
      checkOutput({v.name, " sdo"}, 16'(sdo), 16'(v.din[15-i]));
      checkOutput({v.name, " sdoen"}, 16'(sdoen), 16'(!(isRead && i >= 8)));
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                    (isRead && i >= 8) ? v.sdiByte[15-i] : 1'b1);
      step();
      if (dvalid) pulses++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput({v.name, " dout"}, 16'(dout), 16'(v.expDout));
    checkOutput({v.name, " dvalid_after_last"}, 16'(dvalid), 16'(v.expDvalid));
    checkOutput({v.name, " dvalid_pulses"}, 16'(pulses), 16'(v.expDvalid));
    step();
    checkOutput({v.name, " dvalid_drop"}, 16'(dvalid), 16'd0);
    checkOutput({v.name, " bitcount_wrap"}, 16'(bitcount), 16'd0);
    scen = 1'b0;
    step();
    checkOutput({v.name, " sdoen_idle"}, 16'(sdoen), 16'd0);
  endtask

  initial begin
    vecs[0] = '{"write_2A5C", 16'h2A5C, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{"read_8F00",  16'h8F00, 8'hB6, 8'hB6, 1'b1};
    vecs[2] = '{"write_1234", 16'h1234, 8'hFF, 8'hB6, 1'b0};

    din = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #12;
    checkOutput("rst bitcount", 16'(bitcount), 16'd0);
    checkOutput("rst sdo", 16'(sdo), 16'd0);
    checkOutput("rst sdoen", 16'(sdoen), 16'd0);
    checkOutput("rst dout", 16'(dout), 16'd0);
    checkOutput("rst dvalid", 16'(dvalid), 16'd0);
    reset = 1'b1;
    step();

    for (int k = 0; k < 3; k++)
      runFrame(vecs[k]);

    // Clear has priority over increment
    loadFrame(16'h8F00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
    end
    checkOutput("prio bitcount5", 16'(bitcount), 16'd5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("prio clr_over_en", 16'(bitcount), 16'd0);

    // Load has priority over shift, inside a read data phase
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
    end
    checkOutput("prio sdoen_dataphase", 16'(sdoen), 16'd0);
    din = 16'h8000;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    checkOutput("prio ld_over_sh sdo", 16'(sdo), 16'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    checkOutput("prio next_bit sdo", 16'(sdo), 16'd0);
    checkOutput("prio no_dvalid", 16'(dvalid), 16'd0);
    checkOutput("prio dout_hold", 16'(dout), 16'hB6);

    // Counter wraps after 16 increments
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    checkOutput("wrap bitcount15", 16'(bitcount), 16'd15);
    step();
    checkOutput("wrap bitcount0", 16'(bitcount), 16'd0);

    // Abort a read at bitcount 11
    loadFrame(16'h8F00);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      checkOutput("abort no_dvalid", 16'(dvalid), 16'd0);
    end
    checkOutput("abort bitcount11", 16'(bitcount), 16'd11);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("abort idle dvalid", 16'(dvalid), 16'd0);
    end
    checkOutput("abort dout_hold", 16'(dout), 16'hB6);
    checkOutput("abort sdoen", 16'(sdoen), 16'd0);
    runFrame('{"read_after_abort", 16'h8F00, 8'h3C, 8'h3C, 1'b1});

    // Asynchronous reset in the middle of a read
    loadFrame(16'h8F00);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
    end
    checkOutput("midrst bitcount10", 16'(bitcount), 16'd10);
    #2;
    reset = 1'b0;
    scen = 1'b0;
    #1;
    checkOutput("midrst bitcount", 16'(bitcount), 16'd0);
    checkOutput("midrst sdo", 16'(sdo), 16'd0);
    checkOutput("midrst sdoen", 16'(sdoen), 16'd0);
    checkOutput("midrst dout", 16'(dout), 16'd0);
    checkOutput("midrst dvalid", 16'(dvalid), 16'd0);
    step();
    checkOutput("midrst held dvalid", 16'(dvalid), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    checkOutput("midrst released dvalid", 16'(dvalid), 16'd0);
    checkOutput("midrst released bitcount", 16'(bitcount), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_three_wire_datapath.md
# spi_three_wire_datapath

Datapath companion to the three-wire SPI control FSM: it consumes the FSM's LDEN/SHEN/bitcountEN/rstbitcount/SCEN strobes and returns the bitcount the FSM sequences on. It holds the 16-bit frame shift register (R/W bit + address + data), drives the serial data line MSB-first, and turns the line around for the data phase of read frames. Read data is captured serially and presented as a parallel byte with a one-cycle valid pulse. The pad tristate lives at chip top; this block exports SDO/SDOEN and takes SDI.

## Interface
- ADDR_W, 8, address-phase bits including the R/W bit (frame MSB).
- DATA_W, 8, data-phase bits.
- CNT_W, 4, bitcount width; must satisfy 2^CNT_W == ADDR_W+DATA_W.

- CLK  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- DIN  in  ADDR_W+DATA_W  parallel frame; DIN[MSB]=1 means read.
- LDEN  in  1  load DIN into the shift register.
- SHEN  in  1  shift one bit.
- bitcountEN  in  1  increment bitcount.
- rstbitcount  in  1  synchronous clear of bitcount.
- SCEN  in  1  chip-select active; frame in progress.
- SDI  in  1  serial line as read back from the pad.
- bitcount  out  CNT_W  current bit index, to the FSM.
- SDO  out  1  serial output, shift register MSB.
- SDOEN  out  1  pad output enable.
- DOUT  out  DATA_W  last completed read byte.
- DVALID  out  1  one-cycle pulse: DOUT just updated.

## Operation
- Bit counter: rstbitcount clears to 0, with priority over bitcountEN. Otherwise bitcountEN increments, wrapping 15→0.
- Shift register sreg: LDEN loads DIN and latches rw_q=DIN[MSB]. Else SHEN shifts left, filling LSB with 0. LDEN wins over SHEN in the same cycle; no capture occurs in that cycle.
- SDO = sreg[MSB], combinational from the register.
- Phase: data_phase = (bitcount >= ADDR_W).
- SDOEN = SCEN & ~(rw_q & data_phase), combinational. The line is driven for the whole of a write frame and for the address phase of a read frame.
- Read capture: when SHEN & ~LDEN & rw_q & data_phase, rsh <= {rsh[DATA_W-2:0], SDI}.
- Completion: if that capture happens with bitcount == ADDR_W+DATA_W-1, then on the next edge DOUT <= {rsh[DATA_W-2:0], SDI} and DVALID=1 for exactly one cycle.
- Writes never pulse DVALID and never change DOUT.
- Abort: if SCEN falls before completion, rsh is discarded, DOUT holds, and there is no DVALID. The next LDEN clears rsh.
- SHEN while SCEN=0 still shifts sreg; the FSM must not issue it.

## Timing
- Reset values: bitcount=0, sreg=0, rw_q=0, rsh=0, DOUT=0, DVALID=0, so SDO=0 and SDOEN=0 whenever SCEN=0.
- Reset assertion mid-frame clears all state immediately, with no DVALID. Operation resumes only after a fresh LDEN.
- LDEN at edge t: SDO shows DIN[MSB] after t.
- Each SHEN edge exposes the next bit on SDO.
- Capture uses pre-edge bitcount, so the FSM may assert SHEN and bitcountEN in the same cycle.
- Read latency: the edge sampling the final SDI bit also writes DOUT and raises DVALID. DVALID is high for the following cycle only.
- SDOEN falls in the cycle bitcount reaches ADDR_W on read frames. SDI is ignored while SDOEN=1.

## Structure
- Package spi3w_pkg holds ADDR_W, DATA_W, CNT_W, FRAME_W=ADDR_W+DATA_W, RW_BIT=FRAME_W-1, and the read/write encoding constants. The FSM and testbench import the same package.
- One sub-module, spi3w_bitcounter: clear/enable/wrap counter with async active-low reset.
- Shift, capture and output logic sit in the top module.

## Test plan
- Write: DIN=0x2A5C, LDEN, then 16×(SHEN+bitcountEN) with SCEN=1 → SDO sequence 0010_1010_0101_1100, SDOEN=1 throughout, DVALID never asserts.
- Read: DIN=0x8F00 and SDI driven 1,0,1,1,0,1,1,0 during bits 8–15 → SDOEN drops at bitcount=8, DOUT=0xB6, DVALID high for exactly one cycle after the bit-15 edge.
- Priority: rstbitcount and bitcountEN together at bitcount=5 → bitcount=0. LDEN and SHEN together → sreg=DIN, no shift, no capture.
- Wrap: 16 increments from 0 with no clear → bitcount returns to 0.
- Abort: on a read frame, drop SCEN at bitcount=11 → DOUT keeps its previous value (0xB6) and there is no DVALID. A following full read of 0x3C gives DOUT=0x3C.
- Reset mid-frame: assert reset at bitcount=10 on a read → all outputs return to reset values asynchronously, with no DVALID.
